// File: rtl/async_upcounter_stages_pkg.sv
// Shared constants for the ripple up-counter slice.
package async_upcounter_stages_pkg;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/async_upcounter_stages_ripple_tff_stage.sv
// One ripple toggle stage: a D flop fed from its own complement, with async active-high reset.
module ripple_tff_stage (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic q_o,
    output logic qbar_o
);

    // Toggle on each enabled clock edge; reset forces the stage to 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= 1'b0;
        end else if (en_i) begin
            q_o <= qbar_o;
        end else begin
            q_o <= q_o;
        end
    end

    assign qbar_o = ~q_o;

endmodule

// File: rtl/async_upcounter_stages.sv
// Ripple up counter with enable, flop-sourced clear, clk-domain sampled count and wrap pulse.
module async_upcounter_stages
    import async_upcounter_stages_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] q_sync,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    logic             clr_q;
    logic             stage_rst;
    logic [WIDTH-1:0] stage_clk;
    logic [WIDTH-1:0] stage_en;
    logic [WIDTH-1:0] stage_qbar;

    // Clear comes from a flop, so OR-ing it into the async reset cannot glitch.
    assign stage_rst = rst | clr_q;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_stage
            if (i == 0) begin : g_first
                assign stage_clk[i] = clk;
                assign stage_en[i]  = en & ~clr_q;
            end else begin : g_rest
                // Previous stage falling edge is the rising edge of its complement.
                assign stage_clk[i] = stage_qbar[i-1];
                assign stage_en[i]  = 1'b1;
            end

            ripple_tff_stage u_stage (
                .clk_i  (stage_clk[i]),
                .rst_i  (stage_rst),
                .en_i   (stage_en[i]),
                .q_o    (q[i]),
                .qbar_o (stage_qbar[i])
            );
        end
    endgenerate

    assign qbar = stage_qbar;

    // Clear request, settled count copy and roll-over detect for synchronous consumers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_q  <= 1'b0;
            q_sync <= ALL_ZERO;
            wrap   <= 1'b0;
        end else begin
            clr_q  <= clr;
            q_sync <= q;
            wrap   <= (q_sync == ALL_ONES) && (q == ALL_ZERO) && !clr_q;
        end
    end

endmodule

// File: tb/tb_async_upcounter_stages.sv
// Self-checking bench: directed vector table, randomized run against a counting model, WIDTH=6 build.
module tb_async_upcounter_stages;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic       en6 = 1'b0;
    logic [3:0] q, qbar, q_sync;
    logic       wrap;
    logic [5:0] q6, qbar6, q_sync6;
    logic       wrap6;

    int n_pass  = 0;
    int n_total = 0;

    // Model: the count as a plain integer modulo 16.
    int m_q = 0, m_q_sync = 0;
    bit m_clr_q = 1'b0, m_wrap = 1'b0;

    typedef struct {
        bit en;
        bit clr;
        int q;
        int q_sync;
        bit wrap;
    } vec_t;
    vec_t vecs[$];

    async_upcounter_stages #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .q(q), .qbar(qbar), .q_sync(q_sync), .wrap(wrap)
    );

    async_upcounter_stages #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .en(en6), .clr(clr),
        .q(q6), .qbar(qbar6), .q_sync(q_sync6), .wrap(wrap6)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_q = 0; m_q_sync = 0; m_clr_q = 1'b0; m_wrap = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit c);
        int nqs;
        bit nw;
        nqs = m_q;
        nw  = (m_q_sync == 15) && (m_q == 0) && !m_clr_q;
        if (e && !m_clr_q) m_q = (m_q + 1) % 16;
        if (c) m_q = 0;
        m_clr_q  = c;
        m_q_sync = nqs;
        m_wrap   = nw;
    endtask

    task automatic step(input bit e, input bit c);
        en  = e;
        clr = c;
        @(posedge clk);
        model_edge(e, c);
        #1;
    endtask

    task automatic add(input bit e, input bit c, input int eq, input int eqs, input bit ew);
        vec_t v;
        v.en = e; v.clr = c; v.q = eq; v.q_sync = eqs; v.wrap = ew;
        vecs.push_back(v);
    endtask

    initial begin
        // 20 enabled edges, then enable pattern, clear at 9, climb to F, clear at F.
        for (int k = 1; k <= 20; k++) add(1'b1, 1'b0, k % 16, (k - 1) % 16, k == 17);
        add(1'b1, 1'b0, 5, 4, 1'b0);
        add(1'b1, 1'b0, 6, 5, 1'b0);
        add(1'b0, 1'b0, 6, 6, 1'b0);
        add(1'b0, 1'b0, 6, 6, 1'b0);
        add(1'b1, 1'b0, 7, 6, 1'b0);
        add(1'b1, 1'b0, 8, 7, 1'b0);
        add(1'b1, 1'b0, 9, 8, 1'b0);
        add(1'b1, 1'b1, 0, 9, 1'b0);
        add(1'b1, 1'b0, 0, 0, 1'b0);
        add(1'b1, 1'b0, 1, 0, 1'b0);
        for (int k = 2; k <= 15; k++) add(1'b1, 1'b0, k, k - 1, 1'b0);
        add(1'b1, 1'b1, 0, 15, 1'b0);
        add(1'b1, 1'b0, 0, 0, 1'b0);
        add(1'b1, 1'b0, 1, 0, 1'b0);

        // Reset held for 3 ns with the clock running.
        en = 1'b1;
        #1;
        check("rst_q", q, 0);
        check("rst_qbar", qbar, 15);
        check("rst_q_sync", q_sync, 0);
        check("rst_wrap", wrap, 0);
        #1;
        check("rst_q_t2", q, 0);
        #1;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].clr);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_q_sync", i), q_sync, vecs[i].q_sync);
            check($sformatf("vec%0d_wrap", i), wrap, vecs[i].wrap);
            check($sformatf("vec%0d_qbar", i), qbar, (~vecs[i].q) & 15);
        end

        // Randomized enable/clear traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(9, 0) == 0);
            check($sformatf("rnd%0d_q", i), q, m_q);
            check($sformatf("rnd%0d_q_sync", i), q_sync, m_q_sync);
            check($sformatf("rnd%0d_wrap", i), wrap, m_wrap);
            check($sformatf("rnd%0d_qbar", i), qbar, (~m_q) & 15);
        end

        // Async reset mid-cycle at q=C.
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0);
        check("pre_arst_q", q, 12);
        #2;
        rst = 1'b1;
        #1;
        check("arst_q", q, 0);
        check("arst_q_sync", q_sync, 0);
        check("arst_qbar", qbar, 15);
        check("arst_wrap", wrap, 0);
        @(posedge clk);
        #1;
        check("arst_hold_q", q, 0);
        check("arst_hold_q_sync", q_sync, 0);
        #2;
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0);
        check("post_arst_q1", q, 1);
        check("post_arst_q_sync1", q_sync, 0);
        step(1'b1, 1'b0);
        check("post_arst_q2", q, 2);
        check("post_arst_q_sync2", q_sync, 1);

        // WIDTH=6 build: 70 enabled edges.
        begin
            int wraps = 0;
            en  = 1'b0;
            clr = 1'b0;
            en6 = 1'b1;
            for (int k = 1; k <= 70; k++) begin
                @(posedge clk);
                #1;
                if (wrap6) wraps++;
                check($sformatf("w6_e%0d_q", k), q6, k % 64);
                check($sformatf("w6_e%0d_qbar", k), qbar6, (~(k % 64)) & 63);
                check($sformatf("w6_e%0d_wrap", k), wrap6, k == 65);
            end
            en6 = 1'b0;
            check("w6_final_q", q6, 6);
            check("w6_wrap_count", wraps, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
